// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin, DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on both operand input and result output.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;
    logic             inReady_q;
    logic             outValid_q;

    logic [IW-1:0]    digitBase;
    logic [DIGIT:0]   digitRes_d;

    // One digit of the subtraction; the extra top bit is the borrow out of this digit.
    always_comb begin
        digitBase  = IW'(int'(cnt_q) * DIGIT);
        digitRes_d = {1'b0, a_q[digitBase +: DIGIT]}
                   - {1'b0, b_q[digitBase +: DIGIT]}
                   - {{DIGIT{1'b0}}, borrow_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        borrow_q  <= bin;
                        cnt_q     <= '0;
                        d_q       <= '0;
                        bout_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        inReady_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    d_q[digitBase +: DIGIT] <= digitRes_d[DIGIT-1:0];
                    borrow_q                <= digitRes_d[DIGIT];
                    if (cnt_q == CW'(N - 1)) begin
                        // Differing operand signs with a result sign unlike A is the
                        // same condition as borrow-into-MSB XOR borrow-out-of-MSB.
                        bout_q     <= digitRes_d[DIGIT];
                        ovf_q      <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                    & (a_q[WIDTH-1] ^ digitRes_d[DIGIT-1]);
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (16/4, 4/1, 4/4) checked against an
// integer-arithmetic reference, with directed cases, backpressure, mid-run reset and sweeps.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        bin;
    logic [2:0]  inV, outR, inRdy, outVld, boutS, ovfS;
    logic [15:0] d16;
    logic [3:0]  d41, d44;

    int numVectors = 0;
    int numFails   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(inV[0]), .in_ready(inRdy[0]),
        .a(a), .b(b), .bin(bin), .out_valid(outVld[0]), .out_ready(outR[0]),
        .d(d16), .bout(boutS[0]), .ovf(ovfS[0]));

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .rst(rst), .in_valid(inV[1]), .in_ready(inRdy[1]),
        .a(a[3:0]), .b(b[3:0]), .bin(bin), .out_valid(outVld[1]), .out_ready(outR[1]),
        .d(d41), .bout(boutS[1]), .ovf(ovfS[1]));

    serial_subtractor #(.WIDTH(4), .DIGIT(4)) u44 (
        .clk(clk), .rst(rst), .in_valid(inV[2]), .in_ready(inRdy[2]),
        .a(a[3:0]), .b(b[3:0]), .bin(bin), .out_valid(outVld[2]), .out_ready(outR[2]),
        .d(d44), .bout(boutS[2]), .ovf(ovfS[2]));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int widthOf(input int s);
        return (s == 0) ? 16 : 4;
    endfunction

    function automatic int digitsOf(input int s);
        case (s)
            0:       return 4;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] getD(input int s);
        case (s)
            0:       return d16;
            1:       return {12'b0, d41};
            default: return {12'b0, d44};
        endcase
    endfunction

    // Plain integer arithmetic: unsigned difference, borrow as sign, signed range test.
    function automatic void refSub(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic binv, output logic [15:0] dExp,
                                   output logic bExp, output logic oExp);
        longint span, half, ua, ub, diff, sa, sb, sres;
        span = longint'(1) << w;
        half = span / 2;
        ua   = longint'(av) % span;
        ub   = longint'(bv) % span;
        diff = ua - ub - longint'(binv);
        bExp = (diff < 0);
        dExp = 16'((diff + span) % span);
        sa   = (ua >= half) ? ua - span : ua;
        sb   = (ub >= half) ? ub - span : ub;
        sres = sa - sb - longint'(binv);
        oExp = (sres < -half) || (sres >= half);
    endfunction

    task automatic applyStimulus(input int s, input logic [15:0] av, input logic [15:0] bv,
                                 input logic binv, input int stall);
        logic [15:0] dExp;
        logic        bExp, oExp;
        int          cyc;
        refSub(widthOf(s), av, bv, binv, dExp, bExp, oExp);

        @(negedge clk);
        checkOutput("in_ready before accept", 32'(inRdy[s]), 32'd1);
        a      = av;
        b      = bv;
        bin    = binv;
        inV[s] = 1'b1;
        @(posedge clk);
        #1;
        inV[s] = 1'b0;
        a      = 16'($urandom);
        b      = 16'($urandom);
        bin    = 1'($urandom);
        checkOutput("in_ready after accept", 32'(inRdy[s]), 32'd0);

        cyc = 0;
        while (!outVld[s] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(digitsOf(s)));
        if (!outVld[s]) return;

        checkOutput("d", 32'(getD(s)), 32'(dExp));
        checkOutput("bout", 32'(boutS[s]), 32'(bExp));
        checkOutput("ovf", 32'(ovfS[s]), 32'(oExp));

        // Held in DONE: inputs wiggle but nothing may be accepted or change.
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            inV[s] = 1'($urandom);
            a      = 16'($urandom);
            b      = 16'($urandom);
            bin    = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("stall out_valid", 32'(outVld[s]), 32'd1);
            checkOutput("stall in_ready", 32'(inRdy[s]), 32'd0);
            checkOutput("stall d", 32'(getD(s)), 32'(dExp));
            checkOutput("stall bout/ovf", {30'b0, boutS[s], ovfS[s]}, {30'b0, bExp, oExp});
        end

        // in_valid coinciding with the DONE exit must not be accepted.
        @(negedge clk);
        outR[s] = 1'b1;
        inV[s]  = 1'b1;
        @(posedge clk);
        #1;
        outR[s] = 1'b0;
        inV[s]  = 1'b0;
        checkOutput("out_valid after exit", 32'(outVld[s]), 32'd0);
        checkOutput("in_ready after exit", 32'(inRdy[s]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;
        rst  = 1'b1;
        inV  = '0;
        outR = '0;
        a    = '0;
        b    = '0;
        bin  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checkOutput("reset in_ready", 32'(inRdy[s]), 32'd1);
            checkOutput("reset out_valid", 32'(outVld[s]), 32'd0);
            checkOutput("reset d", 32'(getD(s)), 32'd0);
            checkOutput("reset bout/ovf", {30'b0, boutS[s], ovfS[s]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 16'h0005, 16'h0003, 1'b0, 0);
        applyStimulus(0, 16'h0000, 16'h0001, 1'b0, 1);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b0, 2);
        applyStimulus(0, 16'h1234, 16'h1234, 1'b1, 0);
        applyStimulus(0, 16'h4321, 16'h1234, 1'b0, 5);
        applyStimulus(0, 16'h7FFF, 16'hFFFF, 1'b1, 0);

        // Reset after two digits of a run: no result may ever appear for it.
        @(negedge clk);
        a      = 16'h5555;
        b      = 16'h1111;
        bin    = 1'b0;
        inV[0] = 1'b1;
        @(posedge clk);
        #1;
        inV[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrun reset out_valid", 32'(outVld[0]), 32'd0);
        checkOutput("midrun reset in_ready", 32'(inRdy[0]), 32'd1);
        checkOutput("midrun reset d", 32'(d16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            sawValid = sawValid | outVld[0];
        end
        checkOutput("no result after reset", 32'(sawValid), 32'd0);
        applyStimulus(0, 16'h00FF, 16'h0100, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            applyStimulus(0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        for (int s = 1; s < 3; s++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int ci = 0; ci < 2; ci++)
                        applyStimulus(s, 16'(av), 16'(bv), 1'(ci), int'($urandom_range(0, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numFails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor. It computes D = A − B − Bin over WIDTH-bit operands, processing DIGIT bits per clock, least-significant digit first, with the borrow carried between cycles in a register. It sits behind a valid/ready input handshake and in front of a valid/ready output handshake. It replaces single-bit full-subtractor instances wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, default 16: operand and difference width in bits. Must be ≥ 1 and a multiple of DIGIT.
- DIGIT, default 4: bits processed per cycle. Must satisfy 1 ≤ DIGIT ≤ WIDTH.
- Derived: N = WIDTH/DIGIT, the number of compute cycles.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: reset, asynchronous and active-high.
- in_valid  in  1: operands presented.
- in_ready  out  1: block can accept operands.
- a  in  WIDTH: minuend.
- b  in  WIDTH: subtrahend.
- bin  in  1: borrow in.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- d  out  WIDTH: difference, a − b − bin mod 2^WIDTH.
- bout  out  1: unsigned borrow out; 1 iff a < b + bin.
- ovf  out  1: signed (two's-complement) overflow of a − b − bin.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: holds a digit counter 0..N−1.
  - DONE: out_valid=1.
- IDLE → RUN on an edge with in_valid && in_ready.
  - On that edge, latch a, b and bin into internal registers.
  - Clear the digit counter and the result register.
- RUN, per edge:
  - Subtract digit k of b, plus the borrow register, from digit k of a.
  - Write the DIGIT result bits into d[k*DIGIT +: DIGIT].
  - Update the borrow register.
  - Increment k.
- RUN → DONE on the edge that processes digit N−1.
  - On that edge, set bout to the final borrow.
  - Set ovf = (borrow into bit WIDTH−1) XOR (borrow out of bit WIDTH−1).
- DONE → IDLE on an edge with out_valid && out_ready.
- in_ready=0 in RUN and DONE; a, b, bin and in_valid are ignored there.
- After acceptance, changes on a, b and bin have no effect on the operation in progress.
- d, bout and ovf are registered outputs. They hold stable from DONE entry until the next acceptance.
- No bypass: a result is never produced in the same cycle its operands are accepted. An in_valid arriving in the same cycle as the DONE→IDLE exit is not accepted; it is accepted one cycle later.
- WIDTH=DIGIT (N=1): RUN lasts exactly one edge.
- Reset (asserted at any time, including mid-RUN or in DONE):
  - Outputs: in_ready=1, out_valid=0, d=0, bout=0, ovf=0.
  - State: IDLE, counter=0, borrow register=0.
  - Any operation in flight is discarded, and no out_valid pulse is ever produced for it.

## Timing
- Acceptance edge T0.
- out_valid rises after edge T0+N and stays high until the out_ready edge.
- Latency from acceptance to result: N cycles.
- Minimum initiation interval: N+2 cycles (acceptance, N RUN edges, DONE edge with out_ready=1).
- in_ready falls after T0 and rises after the edge where out_valid && out_ready.
- The reset effect is immediate (asynchronous). Deassertion is synchronous to clk.
- The first acceptance is possible on the first rising edge after rst falls.

## Test plan
- WIDTH=16, DIGIT=4: a=0x0005, b=0x0003, bin=0 → d=0x0002, bout=0, ovf=0; out_valid high exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 → d=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 → d=0x7FFF, bout=0, ovf=1.
- a=0x1234, b=0x1234, bin=1 → d=0xFFFF, bout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b → d, bout and ovf unchanged, in_ready=0, nothing accepted. Then raise out_ready → IDLE next cycle, and the next operation is correct.
- Reset mid-RUN after 2 digits → out_valid stays 0, in_ready=1 and d=0 immediately. The next operation, a=0x00FF, b=0x0100, bin=0 → d=0xFFFF, bout=1, ovf=0.
- Parameter sweep, WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4: all 512 (a, b, bin) combinations checked against the arithmetic reference, with random out_ready stalls.
